uart_echo_buffer: RTL
=====================

# uart_echo_buffer

Buffered UART echo engine between `uart_rx` and `uart_tx`. Received bytes go into a parametrised FIFO and are replayed to the transmitter one at a time under a launch/busy handshake. Optional upper-case conversion and CR→CRLF expansion are applied on output. The block reports sticky overflow and BREAK flags and exposes the last received byte for board LEDs.

## Interface
- `DEPTH`, 16: FIFO entries; power of two, ≥ 2.
- `LW`, $clog2(DEPTH)+1: width of `level`. Derived; do not override.
- `clk`  in  1  system clock.
- `resetn`  in  1  reset, asynchronous, active-low.
- `echo_en`  in  1  1 = received bytes are pushed to the FIFO.
- `upcase_en`  in  1  1 = 0x61–0x7A are converted to 0x41–0x5A on output.
- `crlf_en`  in  1  1 = each transmitted 0x0D is followed by 0x0A.
- `status_clr`  in  1  single-cycle pulse; clears `overflow` and `break_seen`.
- `recv_valid`  in  1  single-cycle strobe from `uart_rx`.
- `recv_data`  in  8  received byte; valid with `recv_valid`.
- `recv_break`  in  1  BREAK strobe from `uart_rx`.
- `tx_busy`  in  1  transmitter busy.
- `tx_enable`  out  1  single-cycle launch strobe to `uart_tx`.
- `tx_data`  out  8  byte to transmit; registered.
- `last_data`  out  8  most recent `recv_data`.
- `level`  out  LW  FIFO occupancy, 0..DEPTH.
- `fifo_empty`, `fifo_full`  out  1  occupancy flags.
- `overflow`  out  1  sticky; a push was dropped.
- `break_seen`  out  1  sticky; a BREAK was received.

## Operation
- Reset values: `tx_enable`=0, `tx_data`=0x00, `last_data`=0x00, `level`=0, `fifo_empty`=1, `fifo_full`=0, `overflow`=0, `break_seen`=0, `lf_pending`=0, FSM=IDLE.
- Receive path:
  - On `recv_valid`, `last_data` ← `recv_data`, independent of `echo_en`.
  - The byte is pushed when `echo_en`=1 and the FIFO is not full.
  - If full with no pop in the same cycle, the byte is dropped and `overflow` ← 1.
  - Push and pop in the same cycle while full: the push is accepted and `level` is unchanged.
- On `recv_break`:
  - FIFO is flushed: pointers and `level` go to 0.
  - `lf_pending` is cleared and `break_seen` ← 1.
  - A `recv_valid` in the same cycle is dropped from the FIFO, but `last_data` still updates.
  - A byte already in flight completes normally.
- `status_clr` clears both sticky flags. If a set event occurs in the same cycle, the set wins.
- Transmit FSM:
  - IDLE: when `lf_pending`=1 and `tx_busy`=0, load `tx_data` ← 0x0A, clear `lf_pending`, go to LAUNCH. Otherwise, when FIFO is not empty and `tx_busy`=0, pop the head and go to LAUNCH. Loaded `tx_data` is the head byte, case-converted if `upcase_en`. Set `lf_pending` ← `crlf_en` & (head == 0x0D); `crlf_en` and `upcase_en` are sampled at pop time.
  - LAUNCH: `tx_enable`=1 for exactly this cycle; go to WAIT_BUSY.
  - WAIT_BUSY: stay until `tx_busy`=1, then go to WAIT_DONE.
  - WAIT_DONE: stay until `tx_busy`=0, then go to IDLE.
- `tx_data` holds its value from load until the next load.
- Pointer arithmetic wraps modulo DEPTH. `level` is exact; no wrap ambiguity at full.

## Timing
- Push: `recv_valid` in cycle N → `level` and flags update in N+1.
- Echo latency from an empty FIFO in IDLE with `tx_busy`=0:
  - N+1: FSM sees non-empty and pops.
  - N+2: `tx_enable`=1 with `tx_data` valid; `level` drops back.
- Between consecutive launches there is at least one full `tx_busy` high→low cycle plus one IDLE cycle.
- LF after CR: launched on the first IDLE cycle after WAIT_DONE exits, before any FIFO pop.
- `fifo_full`, `fifo_empty` and `level` are registered and consistent in the same cycle.
- A `resetn` assertion mid-transmission returns all state to reset values asynchronously.

## Test plan
- Single echo: `echo_en`=1, push 0x41 at cycle N, tx model asserts busy 3 cycles after launch for 10 cycles → `tx_enable` at N+2 with `tx_data`=0x41, `level` 1→0, `last_data`=0x41.
- Upcase + CRLF: `upcase_en`=`crlf_en`=1, push 0x61, 0x0D → transmitted sequence 0x41, 0x0D, 0x0A; exactly 3 `tx_enable` pulses.
- Overflow: DEPTH=16, `tx_busy` held 1, push 17 bytes 0x00..0x10 → `level`=16, `fifo_full`=1, `overflow`=1. After release, output is 0x00..0x0F; 0x10 is lost. `status_clr` → `overflow`=0.
- Full with simultaneous push and pop: fill to 16; push 0xAA in the same cycle as a pop → `overflow` stays 0, `level` stays 16, 0xAA is output last.
- BREAK mid-stream: 5 bytes queued while byte 1 is in flight, `recv_break` pulsed → byte 1 completes, no further `tx_enable`, `level`=0, `break_seen`=1.
- `echo_en`=0: push 0x55 → no `tx_enable`, `level`=0, `last_data`=0x55.

Source files
------------

// File: rtl/uart_echo_buffer_if.sv
// uart_echo_buffer_if: receive strobes and transmit handshake between the echo buffer and the UART
interface uart_echo_buffer_if;
  logic       recv_valid;
  logic [7:0] recv_data;
  logic       recv_break;
  logic       tx_busy;
  logic       tx_enable;
  logic [7:0] tx_data;
  modport slave (
    input  recv_valid, recv_data, recv_break, tx_busy,
    output tx_enable, tx_data
  );
  modport master (
    output recv_valid, recv_data, recv_break, tx_busy,
    input  tx_enable, tx_data
  );
endinterface

// File: rtl/uart_echo_buffer.sv
// uart_echo_buffer: FIFO-buffered UART echo with upper-casing, CR->CRLF expansion and sticky status
module uart_echo_buffer #(
  parameter int DEPTH = 16,
  parameter int LW = $clog2(DEPTH) + 1
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic                echo_en,
  input  logic                upcase_en,
  input  logic                crlf_en,
  input  logic                status_clr,
  uart_echo_buffer_if.slave   bus,
  output logic [7:0]          last_data,
  output logic [LW-1:0]       level,
  output logic                fifo_empty,
  output logic                fifo_full,
  output logic                overflow,
  output logic                break_seen
);
  localparam int AW = $clog2(DEPTH);
  typedef enum logic [1:0] {IDLE, LAUNCH, WAIT_BUSY, WAIT_DONE} state_t;
  state_t state, state_nx;
  logic [7:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [LW-1:0] level_nx;
  logic [7:0] head, head_cvt;
  logic lf_pending, lf_go, pop, push, drop, rx_ok;
  assign head = mem[rd_ptr];
  assign head_cvt = (upcase_en && head >= 8'h61 && head <= 8'h7A) ? head - 8'h20 : head;
  // a BREAK in the same cycle discards the incoming byte from the FIFO
  assign rx_ok = bus.recv_valid & echo_en & ~bus.recv_break;
  // when full, a push is only accepted if the head leaves in the same cycle
  assign push = rx_ok & (~fifo_full | pop);
  assign drop = rx_ok & fifo_full & ~pop;
  assign level_nx = level + LW'(push) - LW'(pop);
  assign bus.tx_enable = (state == LAUNCH);
  // next-state: a pending LF beats the FIFO head; nothing launches during a flush
  always_comb begin
    state_nx = state;
    lf_go = 1'b0;
    pop = 1'b0;
    case (state)
      IDLE: begin
        lf_go = lf_pending & ~bus.tx_busy & ~bus.recv_break;
        pop = ~lf_pending & ~fifo_empty & ~bus.tx_busy & ~bus.recv_break;
        state_nx = (lf_go | pop) ? LAUNCH : IDLE;
      end
      LAUNCH:    state_nx = WAIT_BUSY;
      WAIT_BUSY: state_nx = bus.tx_busy ? WAIT_DONE : WAIT_BUSY;
      default:   state_nx = bus.tx_busy ? WAIT_DONE : IDLE;
    endcase
  end
  // transmit state register
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state <= IDLE;
    else state <= state_nx;
  end
  // FIFO storage; contents need no reset because level gates every read
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= bus.recv_data;
  end
  // pointers, occupancy, pending LF, output byte and sticky flags
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level <= '0;
      fifo_empty <= 1'b1;
      fifo_full <= 1'b0;
      lf_pending <= 1'b0;
      bus.tx_data <= 8'h00;
      last_data <= 8'h00;
      overflow <= 1'b0;
      break_seen <= 1'b0;
    end else begin
      if (bus.recv_break) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        level <= '0;
        fifo_empty <= 1'b1;
        fifo_full <= 1'b0;
        lf_pending <= 1'b0;
      end else begin
        wr_ptr <= push ? wr_ptr + AW'(1) : wr_ptr;
        rd_ptr <= pop ? rd_ptr + AW'(1) : rd_ptr;
        level <= level_nx;
        fifo_empty <= (level_nx == '0);
        fifo_full <= (level_nx == LW'(DEPTH));
        lf_pending <= pop ? (crlf_en & (head == 8'h0D)) : lf_go ? 1'b0 : lf_pending;
      end
      bus.tx_data <= pop ? head_cvt : lf_go ? 8'h0A : bus.tx_data;
      last_data <= bus.recv_valid ? bus.recv_data : last_data;
      overflow <= drop | (overflow & ~status_clr);
      break_seen <= bus.recv_break | (break_seen & ~status_clr);
    end
  end
endmodule
